sram_ctrl: RTL and testbench

Clocked controller for an external asynchronous SRAM with active-low controls and per-byte lane masks (18-bit address, 16-bit data by default). It converts a single-outstanding valid/ready request interface into correctly timed chip-enable, output-enable, write-enable and byte-mask pin sequences. Read and write wait states are parametrised, and a hold cycle follows every write. It sits between the core's memory port and the board SRAM pins.

---
 rtl/sram_pkg.sv | 32 +++
 rtl/sram_ctrl.sv | 118 +++++++++++
 tb/tb_sram_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// sram_pkg -- state encoding, default widths and byte-mask helper for sram_ctrl
// Revision: 1.0
// ============================================================================
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    WHOLD = 2'd3
  } sram_state_t;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  // Widest data bus the mask helper covers; callers truncate to their width.
  localparam int MAX_DATA_W  = 64;
  localparam int MAX_BYTES   = MAX_DATA_W / 8;

  function automatic logic [MAX_DATA_W-1:0] byte_mask(input logic [MAX_BYTES-1:0] be);
    logic [MAX_DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// sram_ctrl -- valid/ready front end driving an asynchronous SRAM with wait states
// Revision: 1.0
// ============================================================================
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W  = SRAM_ADDR_W,
  parameter int DATA_W  = SRAM_DATA_W,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2,
  localparam int BYTES  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BYTES-1:0]  req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [BYTES-1:0]  sram_be_n
);

  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT);
  localparam logic [3:0] WR_LOAD = 4'(WR_WAIT);

  sram_state_t       state;
  logic [3:0]        wait_cnt;
  logic [DATA_W-1:0] wdata_q;
  logic [BYTES-1:0]  be_q;
  logic              data_oe;

  // The data-bus enable is a flop so the pins never glitch onto the bus.
  assign sram_data = data_oe ? wdata_q : {DATA_W{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      wdata_q   <= '0;
      be_q      <= '0;
      data_oe   <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      sram_addr <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_be_n <= '1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            sram_addr <= req_addr;
            wdata_q   <= req_wdata;
            be_q      <= req_be;
            sram_ce_n <= 1'b0;
            sram_be_n <= ~req_be;
            req_ready <= 1'b0;
            if (req_we) begin
              state     <= WRITE;
              wait_cnt  <= WR_LOAD;
              sram_we_n <= 1'b0;
              data_oe   <= 1'b1;
            end else begin
              state     <= READ;
              wait_cnt  <= RD_LOAD;
              sram_oe_n <= 1'b0;
            end
          end
        end
        READ: begin
          if (wait_cnt == 4'd0) begin
            rsp_rdata <= sram_data & DATA_W'(byte_mask(MAX_BYTES'(be_q)));
            rsp_valid <= 1'b1;
            state     <= IDLE;
            req_ready <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_be_n <= '1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        WRITE: begin
          if (wait_cnt == 4'd0) begin
            state     <= WHOLD;
            sram_we_n <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        WHOLD: begin
          // we_n has already risen; release address/data one cycle later.
          state     <= IDLE;
          req_ready <= 1'b1;
          sram_ce_n <= 1'b1;
          sram_be_n <= '1;
          data_oe   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sram_ctrl -- directed vector bench for sram_ctrl with pin-level SRAM models
// Revision: 1.0
// ============================================================================
module tb_sram_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  // Instance A: 16-bit bus, two wait states each way
  logic        a_valid, a_we;
  logic [17:0] a_addr;
  logic [15:0] a_wdata;
  logic [1:0]  a_be;
  logic        a_ready, a_rsp_valid, a_ce_n, a_oe_n, a_we_n;
  logic [15:0] a_rsp_rdata;
  logic [17:0] a_sram_addr;
  logic [1:0]  a_be_n;
  wire  [15:0] a_sram_data;

  // Instance B: 32-bit bus, no wait states
  logic        b_valid, b_we;
  logic [17:0] b_addr;
  logic [31:0] b_wdata;
  logic [3:0]  b_be;
  logic        b_ready, b_rsp_valid, b_ce_n, b_oe_n, b_we_n;
  logic [31:0] b_rsp_rdata;
  logic [17:0] b_sram_addr;
  logic [3:0]  b_be_n;
  wire  [31:0] b_sram_data;

  sram_ctrl u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_addr(a_addr), .req_wdata(a_wdata), .req_be(a_be), .rsp_valid(a_rsp_valid),
    .rsp_rdata(a_rsp_rdata), .sram_addr(a_sram_addr), .sram_data(a_sram_data),
    .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n), .sram_we_n(a_we_n), .sram_be_n(a_be_n)
  );

  sram_ctrl #(.ADDR_W(18), .DATA_W(32), .RD_WAIT(0), .WR_WAIT(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_addr(b_addr), .req_wdata(b_wdata), .req_be(b_be), .rsp_valid(b_rsp_valid),
    .rsp_rdata(b_rsp_rdata), .sram_addr(b_sram_addr), .sram_data(b_sram_data),
    .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n), .sram_be_n(b_be_n)
  );

  // Behavioural asynchronous SRAMs; the probe drives a known pattern to show the bus is released.
  logic [15:0] mem_a [0:(1<<18)-1];
  logic [31:0] mem_b [0:(1<<18)-1];
  logic        probe_a = 1'b0;

  assign a_sram_data = probe_a ? 16'h5A5A :
                       (!a_ce_n && !a_oe_n && a_we_n) ? mem_a[a_sram_addr] : 16'hzzzz;
  assign b_sram_data = (!b_ce_n && !b_oe_n && b_we_n) ? mem_b[b_sram_addr] : 32'hzzzzzzzz;

  always @(posedge a_we_n) begin
    if (!a_ce_n)
      for (int i = 0; i < 2; i++)
        if (!a_be_n[i]) mem_a[a_sram_addr][8*i +: 8] <= a_sram_data[8*i +: 8];
  end

  always @(posedge b_we_n) begin
    if (!b_ce_n)
      for (int i = 0; i < 4; i++)
        if (!b_be_n[i]) mem_b[b_sram_addr][8*i +: 8] <= b_sram_data[8*i +: 8];
  end

  always @(negedge clk) begin
    if ((!a_oe_n && !a_we_n) || (!b_oe_n && !b_we_n)) overlap <= overlap + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One complete access; returns cycle numbers counted from the accept cycle (0).
  task automatic run_txn(input bit wide, input logic we, input logic [17:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output int ready_cyc, output int rsp_cyc, output int rsp_cnt,
                         output logic [31:0] rdata, output int strobe_cyc,
                         output int hold_cyc, output bit pins_ok);
    int guard;
    ready_cyc = -1; rsp_cyc = -1; rsp_cnt = 0; rdata = '0;
    strobe_cyc = 0; hold_cyc = 0; pins_ok = 1'b1;
    guard = 0;
    while (!(wide ? b_ready : a_ready) && guard < 50) begin
      @(negedge clk); guard++;
    end
    if (wide) begin
      b_valid = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; b_be = be;
    end else begin
      a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata[15:0]; a_be = be[1:0];
    end
    @(negedge clk);
    // Scramble the request inputs to prove the controller latched them.
    a_valid = 1'b0; b_valid = 1'b0;
    a_we = ~we; a_addr = ~addr; a_wdata = ~wdata[15:0]; a_be = ~be[1:0];
    b_we = ~we; b_addr = ~addr; b_wdata = ~wdata; b_be = ~be;
    for (int c = 1; c <= 40; c++) begin
      if (wide) begin
        if (!b_we_n) strobe_cyc++;
        if (!b_ce_n && b_we_n && b_oe_n) hold_cyc++;
        if (!b_ce_n && (b_sram_addr != addr || b_be_n != ~be)) pins_ok = 1'b0;
        if (b_rsp_valid) begin rsp_cyc = c; rsp_cnt++; rdata = b_rsp_rdata; end
        if (b_ready) begin ready_cyc = c; break; end
      end else begin
        if (!a_we_n) strobe_cyc++;
        if (!a_ce_n && a_we_n && a_oe_n) hold_cyc++;
        if (!a_ce_n && (a_sram_addr != addr || a_be_n != ~be[1:0])) pins_ok = 1'b0;
        if (a_rsp_valid) begin rsp_cyc = c; rsp_cnt++; rdata = {16'h0, a_rsp_rdata}; end
        if (a_ready) begin ready_cyc = c; break; end
      end
      @(negedge clk);
    end
  endtask

  typedef struct {
    bit          wide;
    logic        we;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int rc, sc, sn, wc, hc, g;
    int acc [3];
    logic [31:0] rd;
    logic [15:0] rsp_data [2];
    bit ok, rsp_seen;
    int idx, cyc;

    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "time limit reached");
  end

  initial begin
    int rc, sc, sn, wc, hc, g;
    int acc [3];
    logic [31:0] rd;
    logic [15:0] rsp_data [2];
    bit ok, rsp_seen;
    int idx, cyc;

    vecs[0]  = '{0, 1'b1, 18'h00010, 32'h0000BEEF, 4'b0011, 32'h0};
    vecs[1]  = '{0, 1'b0, 18'h00010, 32'h0,        4'b0011, 32'h0000BEEF};
    vecs[2]  = '{0, 1'b1, 18'h3FFFF, 32'h0000ABCD, 4'b0001, 32'h0};
    vecs[3]  = '{0, 1'b0, 18'h3FFFF, 32'h0,        4'b0011, 32'h000012CD};
    vecs[4]  = '{0, 1'b0, 18'h3FFFF, 32'h0,        4'b0010, 32'h00001200};
    vecs[5]  = '{0, 1'b0, 18'h3FFFF, 32'h0,        4'b0000, 32'h00000000};
    vecs[6]  = '{0, 1'b1, 18'h00020, 32'h00005555, 4'b0000, 32'h0};
    vecs[7]  = '{0, 1'b0, 18'h00020, 32'h0,        4'b0011, 32'h00007E7E};
    vecs[8]  = '{0, 1'b0, 18'h00010, 32'h0,        4'b0001, 32'h000000EF};
    vecs[9]  = '{1, 1'b1, 18'h00005, 32'hAABBCCDD, 4'b0101, 32'h0};
    vecs[10] = '{1, 1'b0, 18'h00005, 32'h0,        4'b1111, 32'h11BB33DD};
    vecs[11] = '{1, 1'b0, 18'h00005, 32'h0,        4'b0001, 32'h000000DD};
    vecs[12] = '{1, 1'b0, 18'h00005, 32'h0,        4'b0010, 32'h00003300};
    vecs[13] = '{1, 1'b0, 18'h00005, 32'h0,        4'b0100, 32'h00BB0000};
    vecs[14] = '{1, 1'b0, 18'h00005, 32'h0,        4'b1000, 32'h11000000};

    mem_a[18'h3FFFF] = 16'h1234;
    mem_a[18'h00020] = 16'h7E7E;
    mem_a[18'h00100] = 16'h1111;
    mem_a[18'h00200] = 16'h2222;
    mem_b[18'h00005] = 32'h11223344;

    rst_n = 1'b0;
    a_valid = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_be = '0;
    b_valid = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_be = '0;
    repeat (3) @(negedge clk);
    chk("reset ce_n", a_ce_n, 1);
    chk("reset oe_n", a_oe_n, 1);
    chk("reset we_n", a_we_n, 1);
    chk("reset be_n", a_be_n, 2'b11);
    chk("reset ready", a_ready, 1);
    chk("reset rsp_valid", a_rsp_valid, 0);
    chk("reset rsp_rdata", a_rsp_rdata, 0);
    chk("reset sram_addr", a_sram_addr, 0);
    probe_a = 1'b1; #1;
    chk("reset data released", a_sram_data, 16'h5A5A);
    probe_a = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle ready", a_ready, 1);
    chk("idle ce_n", a_ce_n, 1);
    chk("idle b ce_n", b_ce_n, 1);

    for (int v = 0; v < 15; v++) begin
      run_txn(vecs[v].wide, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].be,
              rc, sc, sn, rd, wc, hc, ok);
      chk($sformatf("v%0d pins", v), ok, 1);
      if (vecs[v].we) begin
        chk($sformatf("v%0d write next-accept cycle", v), rc, vecs[v].wide ? 3 : 5);
        chk($sformatf("v%0d we_n low cycles", v), wc, vecs[v].wide ? 1 : 3);
        chk($sformatf("v%0d hold cycles", v), hc, 1);
        chk($sformatf("v%0d write rsp count", v), sn, 0);
      end else begin
        chk($sformatf("v%0d rsp cycle", v), sc, vecs[v].wide ? 2 : 4);
        chk($sformatf("v%0d read next-accept cycle", v), rc, vecs[v].wide ? 2 : 4);
        chk($sformatf("v%0d rsp count", v), sn, 1);
        chk($sformatf("v%0d rdata", v), rd, vecs[v].exp);
      end
    end

    // Held-valid stream: read 0x100, read 0x200, write 0x300.
    g = 0;
    while (!a_ready && g < 50) begin @(negedge clk); g++; end
    a_valid = 1'b1; a_we = 1'b0; a_addr = 18'h00100; a_be = 2'b11; a_wdata = 16'h0;
    idx = 0; cyc = 0; sn = 0;
    acc[0] = -1; acc[1] = -1; acc[2] = -1; rsp_data[0] = '0; rsp_data[1] = '0;
    while (idx < 3 && cyc < 40) begin
      if (a_rsp_valid && sn < 2) begin rsp_data[sn] = a_rsp_rdata; sn++; end
      if (a_ready) begin acc[idx] = cyc; idx++; end
      @(negedge clk); cyc++;
      if (idx == 1) begin a_addr = 18'h00200; end
      if (idx == 2) begin a_we = 1'b1; a_addr = 18'h00300; a_wdata = 16'hC0DE; end
      if (idx == 3) a_valid = 1'b0;
    end
    repeat (6) @(negedge clk);
    chk("b2b accept A", acc[0], 0);
    chk("b2b accept B", acc[1], 4);
    chk("b2b accept C", acc[2], 8);
    chk("b2b rsp count", sn, 2);
    chk("b2b rdata A", rsp_data[0], 16'h1111);
    chk("b2b rdata B", rsp_data[1], 16'h2222);
    chk("b2b write C", mem_a[18'h00300], 16'hC0DE);

    // Abort a write with an asynchronous reset in its second strobe cycle.
    g = 0;
    while (!a_ready && g < 50) begin @(negedge clk); g++; end
    a_valid = 1'b1; a_we = 1'b1; a_addr = 18'h00040; a_wdata = 16'h9999; a_be = 2'b11;
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    chk("abort strobe active", a_we_n, 0);
    rst_n = 1'b0; #1;
    chk("abort we_n", a_we_n, 1);
    chk("abort ce_n", a_ce_n, 1);
    chk("abort be_n", a_be_n, 2'b11);
    probe_a = 1'b1; #1;
    chk("abort data released", a_sram_data, 16'h5A5A);
    probe_a = 1'b0;
    rsp_seen = 1'b0;
    repeat (2) @(negedge clk) if (a_rsp_valid) rsp_seen = 1'b1;
    rst_n = 1'b1;
    repeat (6) @(negedge clk) if (a_rsp_valid) rsp_seen = 1'b1;
    chk("abort no rsp", rsp_seen, 0);
    chk("abort ready", a_ready, 1);
    chk("oe_n/we_n never both low", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
